// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data memory: FSM state encoding,
//                load/store op codes, access-size codes and default latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_ack  = 2'd2;

    // Default number of stall cycles per access
    localparam int c_default_latency = 4;

    // Load funct3 codes (MEM_READ[2:0])
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // Store select codes (MEM_WRITE[1:0])
    localparam logic [1:0] c_ws_sb = 2'b00;
    localparam logic [1:0] c_ws_sh = 2'b01;
    localparam logic [1:0] c_ws_sw = 2'b10;

    // Access size codes
    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

    // Reserved load codes fall through to a word access
    function automatic logic [1:0] load_size(input logic [2:0] funct3);
        logic [1:0] v_size;
        case (funct3)
            c_f3_lb, c_f3_lbu: v_size = c_size_byte;
            c_f3_lh, c_f3_lhu: v_size = c_size_half;
            default:           v_size = c_size_word;
        endcase
        return v_size;
    endfunction

    // Store code 11 falls through to a word access
    function automatic logic [1:0] store_size(input logic [1:0] sel);
        logic [1:0] v_size;
        case (sel)
            c_ws_sb: v_size = c_size_byte;
            c_ws_sh: v_size = c_size_half;
            default: v_size = c_size_word;
        endcase
        return v_size;
    endfunction

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_align.sv
// ============================================================================
//  Module      : dmem_align
//  Description : Combinational lane logic for the data memory. Extracts and
//                sign/zero-extends load lanes, merges store lanes into the
//                addressed word, and flags misaligned half/word accesses.
//                Offending low address bits are forced to natural alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic        i_is_read,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_store_sel,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word,
    output logic        o_misalign
);

    logic [1:0]  w_size;
    logic [1:0]  w_offset;
    logic [4:0]  w_shift;
    logic [31:0] w_lane;
    logic [31:0] w_lane_mask;
    logic [31:0] w_mask;
    logic        w_unsigned;

    assign w_size     = i_is_read ? load_size(i_funct3) : store_size(i_store_sel);
    assign w_unsigned = (i_funct3 == c_f3_lbu) || (i_funct3 == c_f3_lhu);

    // Byte offset of the lane, forced to natural alignment, plus misalign flag
    always_comb begin
        w_offset    = 2'b00;
        w_misalign_calc();
        w_lane_mask = 32'hFFFF_FFFF;
        case (w_size)
            c_size_byte: begin
                w_offset    = i_addr_lo;
                w_lane_mask = 32'h0000_00FF;
            end
            c_size_half: begin
                w_offset    = {i_addr_lo[1], 1'b0};
                w_lane_mask = 32'h0000_FFFF;
            end
            default: begin
                w_offset    = 2'b00;
                w_lane_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    // Half needs bit 0 clear, word needs both low bits clear
    function automatic void w_misalign_calc();
    endfunction

    assign o_misalign = ((w_size == c_size_half) && i_addr_lo[0]) ||
                        ((w_size == c_size_word) && (i_addr_lo != 2'b00));

    assign w_shift = {w_offset, 3'b000};
    assign w_lane  = i_mem_word >> w_shift;
    assign w_mask  = w_lane_mask << w_shift;

    // Load extension by access size
    always_comb begin
        o_load_data = w_lane;
        case (w_size)
            c_size_byte: o_load_data = {{24{~w_unsigned & w_lane[7]}},  w_lane[7:0]};
            c_size_half: o_load_data = {{16{~w_unsigned & w_lane[15]}}, w_lane[15:0]};
            default:     o_load_data = w_lane;
        endcase
    end

    assign o_store_word = (i_mem_word & ~w_mask) | ((i_store_data << w_shift) & w_mask);

endmodule : dmem_align

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
//  Module      : data_memory
//  Description : Multi-cycle 32-bit data memory with byte/half/word loads and
//                stores. BUSYWAIT stalls the pipeline for LATENCY cycles per
//                access, followed by a one-cycle ACK with READ_DATA valid.
//                Optional macro DATA_MEMORY_MISALIGN_CHECK_EN turns misaligned
//                accesses into flagged no-ops instead of aligning them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = c_default_latency
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  MEM_READ,
    input  logic [2:0]  MEM_WRITE,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGN
);

    localparam int                 c_depth    = 2 ** ADDR_WIDTH;
    localparam int                 c_cnt_w    = $clog2(LATENCY);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LATENCY - 1);

    logic [1:0]            r_state;
    logic [c_cnt_w-1:0]    r_count;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_is_read;
    logic                  r_is_write;
    logic [2:0]            r_funct3;
    logic [1:0]            r_store_sel;
    logic [31:0]           r_read_data;
    logic [31:0]           r_mem [c_depth];

    logic                  w_req;
    logic                  w_idle;
    logic                  w_busy;
    logic                  w_last;
    logic                  w_block;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_word_idx;
    logic [31:0]           w_mem_word;
    logic [31:0]           w_load_data;
    logic [31:0]           w_store_word;
    logic                  w_align_mis;

    assign w_req      = MEM_READ[3] | MEM_WRITE[2];
    assign w_idle     = (r_state == c_st_idle);
    assign w_busy     = (r_state == c_st_busy);
    assign w_last     = w_busy && (r_count == c_cnt_last);
    assign w_word_idx = r_addr[ADDR_WIDTH+1:2];
    assign w_mem_word = r_mem[w_word_idx];

    // Stall is combinational in IDLE so the request cycle itself stalls
    assign BUSYWAIT  = RST & ((w_idle & w_req) | w_busy);
    assign READ_DATA = r_read_data;

    // Upper address bits are intentionally dropped so the array wraps
    generate
        if (ADDR_WIDTH < 30) begin : g_addr_hi_unused
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^ADDR[31:ADDR_WIDTH+2];
        end
    endgenerate

    dmem_align u_align (
        .i_addr_lo    (r_addr[1:0]),
        .i_is_read    (r_is_read),
        .i_funct3     (r_funct3),
        .i_store_sel  (r_store_sel),
        .i_mem_word   (w_mem_word),
        .i_store_data (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word),
        .o_misalign   (w_align_mis)
    );

`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_block  = w_align_mis;
    assign MISALIGN = r_misalign;

    // Misalign flag is raised only for the ACK cycle of an offending access
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_last & w_align_mis;
        end
    end
`else
    logic w_unused_align_mis;

    assign w_block            = 1'b0;
    assign w_unused_align_mis = w_align_mis;
    assign MISALIGN           = 1'b0;
`endif

    // Read wins over write; blocked or reset-interrupted accesses never write
    assign w_mem_we = RST & w_last & r_is_write & ~r_is_read & ~w_block;

    // Access FSM: capture in IDLE, count in BUSY, one-cycle ACK
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= c_st_idle;
            r_count     <= '0;
            r_read_data <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_req) begin
                        r_addr      <= ADDR[ADDR_WIDTH+1:0];
                        r_wdata     <= WRITE_DATA;
                        r_is_read   <= MEM_READ[3];
                        r_is_write  <= MEM_WRITE[2];
                        r_funct3    <= MEM_READ[2:0];
                        r_store_sel <= MEM_WRITE[1:0];
                        r_count     <= c_cnt_one;
                        r_state     <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (r_count == c_cnt_last) begin
                        r_state <= c_st_ack;
                        if (w_block) begin
                            r_read_data <= 32'h0;
                        end else if (r_is_read) begin
                            r_read_data <= w_load_data;
                        end
                    end else begin
                        r_count <= r_count + c_cnt_one;
                    end
                end
                c_st_ack: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Array storage, deliberately untouched by reset
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_word_idx] <= w_store_word;
        end
    end

endmodule : data_memory

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
//  Module      : tb_data_memory
//  Description : Self-checking bench for data_memory with a byte-level
//                reference model. Honours DATA_MEMORY_MISALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;

    localparam int AW    = 8;
    localparam int LAT   = 4;
    localparam int DEPTH = 2 ** AW;

    logic        CLK;
    logic        RST;
    logic [31:0] ADDR;
    logic [31:0] WRITE_DATA;
    logic [3:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGN;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;

    data_memory #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADDR       (ADDR),
        .WRITE_DATA (WRITE_DATA),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .READ_DATA  (READ_DATA),
        .BUSYWAIT   (BUSYWAIT),
        .MISALIGN   (MISALIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic drive_idle();
        MEM_READ   = 4'b0;
        MEM_WRITE  = 3'b0;
        ADDR       = 32'h0;
        WRITE_DATA = 32'h0;
    endtask

    // Reference model: byte lanes of a word array, plain arithmetic extension
    task automatic model_apply(input logic [3:0] rd, input logic [2:0] wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] exp_rd, output logic exp_mis);
        int          idx, off, size;
        logic [7:0]  b [4];
        logic [31:0] w;
        longint      val;
        bit          uns;
        idx     = int'((addr >> 2) % DEPTH);
        off     = int'(addr % 4);
        exp_mis = 1'b0;
        if (rd[3]) begin
            size = (rd[2:0] == 3'd0 || rd[2:0] == 3'd4) ? 1 :
                   (rd[2:0] == 3'd1 || rd[2:0] == 3'd5) ? 2 : 4;
        end else begin
            size = (wr[1:0] == 2'd0) ? 1 : (wr[1:0] == 2'd1) ? 2 : 4;
        end
        if (off % size != 0) begin
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
            exp_mis  = 1'b1;
            model_rd = 32'h0;
            exp_rd   = model_rd;
            return;
`else
            off = off - (off % size);
`endif
        end
        w = model_mem[idx];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (rd[3]) begin
            val = 0;
            for (int i = 0; i < size; i++) val = val + (longint'(b[off+i]) << (8*i));
            uns = (rd[2:0] == 3'd4) || (rd[2:0] == 3'd5);
            if (!uns && size < 4 && val >= (longint'(1) << (8*size-1)))
                val = val - (longint'(1) << (8*size));
            model_rd = val[31:0];
        end else begin
            for (int i = 0; i < size; i++) b[off+i] = wdata[8*i +: 8];
            model_mem[idx] = {b[3], b[2], b[1], b[0]};
        end
        exp_rd = model_rd;
    endtask

    // Issue one request, scramble inputs after capture, return stall count and ACK values
    task automatic do_access(input logic [3:0] rd, input logic [2:0] wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int busy_n, output logic [31:0] rdata,
                             output logic mis, output logic mis_busy);
        bit started, scrambled, done;
        MEM_READ   = rd;
        MEM_WRITE  = wr;
        ADDR       = addr;
        WRITE_DATA = wdata;
        busy_n     = 0;
        started    = 0;
        scrambled  = 0;
        done       = 0;
        rdata      = 32'hx;
        mis        = 1'bx;
        mis_busy   = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (BUSYWAIT) begin
                busy_n++;
                started  = 1;
                mis_busy = mis_busy | MISALIGN;
            end else if (started) begin
                rdata = READ_DATA;
                mis   = MISALIGN;
                done  = 1;
            end
            if (!done) begin
                @(negedge CLK);
                if (started && !scrambled) begin
                    MEM_READ   = {1'b0, 3'($urandom_range(0, 7))};
                    MEM_WRITE  = {1'b0, 2'($urandom_range(0, 3))};
                    ADDR       = $urandom;
                    WRITE_DATA = $urandom;
                    scrambled  = 1;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: addr %h got no ACK within 40 cycles, required ACK", addr);
        end
    endtask

    task automatic test_reset();
        RST        = 1'b0;
        MEM_READ   = 4'b0;
        MEM_WRITE  = 3'b110;
        ADDR       = 32'h40;
        WRITE_DATA = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (BUSYWAIT !== 1'b0) begin
                errors++;
                $display("FAIL reset_busywait: got %b required 0", BUSYWAIT);
            end
        end
        checks++;
        if (READ_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_read_data: got %h required 00000000", READ_DATA);
        end
        checks++;
        if (MISALIGN !== 1'b0) begin
            errors++;
            $display("FAIL reset_misalign: got %b required 0", MISALIGN);
        end
        drive_idle();
        model_rd = 32'h0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL idle_busywait: got %b required 0", BUSYWAIT);
        end
    endtask

    task automatic test_fill();
        int busy_n; logic [31:0] rdata, exp_rd, a, d; logic mis, mis_b, exp_mis;
        for (int w = 0; w < DEPTH; w++) begin
            a = (32'(w) << 2) | ($urandom_range(0, 3) << 10);
            d = $urandom;
            model_apply(4'b0, 3'b110, a, d, exp_rd, exp_mis);
            do_access(4'b0, 3'b110, a, d, busy_n, rdata, mis, mis_b);
            checks++;
            if (busy_n != LAT) begin
                errors++;
                $display("FAIL fill_busy_cycles: addr %h got %0d required %0d", a, busy_n, LAT);
            end
        end
    endtask

    task automatic test_word();
        int busy_n; logic [31:0] rdata, exp_rd; logic mis, mis_b, exp_mis;
        model_apply(4'b0, 3'b110, 32'h10, 32'hDEADBEEF, exp_rd, exp_mis);
        do_access(4'b0, 3'b110, 32'h10, 32'hDEADBEEF, busy_n, rdata, mis, mis_b);
        checks++;
        if (busy_n != 4) begin
            errors++;
            $display("FAIL sw_busy_cycles: got %0d required 4", busy_n);
        end
        model_apply(4'b1010, 3'b0, 32'h10, 32'h0, exp_rd, exp_mis);
        do_access(4'b1010, 3'b0, 32'h10, 32'h0, busy_n, rdata, mis, mis_b);
        checks++;
        if (busy_n != 4) begin
            errors++;
            $display("FAIL lw_busy_cycles: got %0d required 4", busy_n);
        end
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_data: got %h required deadbeef", rdata);
        end
        // Word index wraps modulo 2^ADDR_WIDTH
        model_apply(4'b0, 3'b110, 32'h400, 32'h12345678, exp_rd, exp_mis);
        do_access(4'b0, 3'b110, 32'h400, 32'h12345678, busy_n, rdata, mis, mis_b);
        model_apply(4'b1010, 3'b0, 32'h0, 32'h0, exp_rd, exp_mis);
        do_access(4'b1010, 3'b0, 32'h0, 32'h0, busy_n, rdata, mis, mis_b);
        checks++;
        if (rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL wrap_data: got %h required 12345678", rdata);
        end
    endtask

    task automatic test_subword();
        int busy_n; logic [31:0] rdata, exp_rd; logic mis, mis_b, exp_mis;
        logic [3:0]  rds [5] = '{4'b1010, 4'b1000, 4'b1100, 4'b1001, 4'b1101};
        logic [31:0] ads [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exps[5] = '{32'h80223344, 32'hFFFFFF80, 32'h00000080,
                                 32'hFFFF8022, 32'h00008022};
        model_apply(4'b0, 3'b110, 32'h10, 32'h11223344, exp_rd, exp_mis);
        do_access(4'b0, 3'b110, 32'h10, 32'h11223344, busy_n, rdata, mis, mis_b);
        model_apply(4'b0, 3'b100, 32'h13, 32'h12345680, exp_rd, exp_mis);
        do_access(4'b0, 3'b100, 32'h13, 32'h12345680, busy_n, rdata, mis, mis_b);
        for (int i = 0; i < 5; i++) begin
            model_apply(rds[i], 3'b0, ads[i], 32'h0, exp_rd, exp_mis);
            do_access(rds[i], 3'b0, ads[i], 32'h0, busy_n, rdata, mis, mis_b);
            checks++;
            if (rdata !== exps[i]) begin
                errors++;
                $display("FAIL subword_load[%0d]: op %b addr %h got %h required %h",
                         i, rds[i], ads[i], rdata, exps[i]);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        int busy_n; logic [31:0] rdata, exp_rd; logic mis, mis_b, exp_mis;
        model_apply(4'b0, 3'b110, 32'h20, 32'hA5A50F0F, exp_rd, exp_mis);
        do_access(4'b0, 3'b110, 32'h20, 32'hA5A50F0F, busy_n, rdata, mis, mis_b);
        drive_idle();
        @(negedge CLK);
        MEM_WRITE  = 3'b110;
        ADDR       = 32'h20;
        WRITE_DATA = 32'h55;
        #1;
        checks++;
        if (BUSYWAIT !== 1'b1) begin
            errors++;
            $display("FAIL abort_request_stall: got %b required 1", BUSYWAIT);
        end
        @(negedge CLK);
        drive_idle();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        #1;
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL abort_busywait: got %b required 0", BUSYWAIT);
        end
        checks++;
        if (READ_DATA !== 32'h0) begin
            errors++;
            $display("FAIL abort_read_data: got %h required 00000000", READ_DATA);
        end
        RST      = 1'b1;
        model_rd = 32'h0;
        model_apply(4'b1010, 3'b0, 32'h20, 32'h0, exp_rd, exp_mis);
        do_access(4'b1010, 3'b0, 32'h20, 32'h0, busy_n, rdata, mis, mis_b);
        checks++;
        if (rdata !== 32'hA5A50F0F) begin
            errors++;
            $display("FAIL abort_word_unchanged: got %h required a5a50f0f", rdata);
        end
    endtask

    task automatic test_back_to_back();
        int busy_n; logic [31:0] rdata, exp_rd, a, d; logic [3:0] rd; logic [2:0] wr;
        logic mis, mis_b, exp_mis;
        for (int i = 0; i < 8; i++) begin
            rd = (i % 2 == 0) ? 4'b1010 : 4'b0;
            wr = (i % 2 == 0) ? 3'b0 : 3'b110;
            a  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            model_apply(rd, wr, a, d, exp_rd, exp_mis);
            do_access(rd, wr, a, d, busy_n, rdata, mis, mis_b);
            checks++;
            if (busy_n != LAT || rdata !== exp_rd) begin
                errors++;
                $display("FAIL back_to_back[%0d]: busy %0d data %h required busy %0d data %h",
                         i, busy_n, rdata, LAT, exp_rd);
            end
        end
    endtask

    task automatic test_random();
        int busy_n, kind; logic [31:0] rdata, exp_rd, a, d; logic [3:0] rd; logic [2:0] wr;
        logic mis, mis_b, exp_mis;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            rd   = {kind != 1, 3'($urandom_range(0, 7))};
            wr   = {kind != 0, 2'($urandom_range(0, 3))};
            a    = $urandom;
            d    = $urandom;
            model_apply(rd, wr, a, d, exp_rd, exp_mis);
            do_access(rd, wr, a, d, busy_n, rdata, mis, mis_b);
            checks++;
            if (busy_n != LAT || rdata !== exp_rd || mis !== exp_mis || mis_b !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d]: rd %b wr %b addr %h got busy %0d data %h mis %b/%b required busy %0d data %h mis %b/0",
                         i, rd, wr, a, busy_n, rdata, mis, mis_b, LAT, exp_rd, exp_mis);
            end
            drive_idle();
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
    endtask

`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
    task automatic test_misalign();
        int busy_n; logic [31:0] rdata, exp_rd; logic mis, mis_b, exp_mis;
        model_apply(4'b0, 3'b110, 32'h0, 32'hCAFEF00D, exp_rd, exp_mis);
        do_access(4'b0, 3'b110, 32'h0, 32'hCAFEF00D, busy_n, rdata, mis, mis_b);
        model_apply(4'b1010, 3'b0, 32'h0, 32'h0, exp_rd, exp_mis);
        do_access(4'b1010, 3'b0, 32'h0, 32'h0, busy_n, rdata, mis, mis_b);
        model_apply(4'b1010, 3'b0, 32'h2, 32'h0, exp_rd, exp_mis);
        do_access(4'b1010, 3'b0, 32'h2, 32'h0, busy_n, rdata, mis, mis_b);
        checks++;
        if (rdata !== 32'h0 || mis !== 1'b1 || mis_b !== 1'b0 || busy_n != 4) begin
            errors++;
            $display("FAIL misalign_lw: data %h mis %b busy-mis %b busy %0d required 00000000 1 0 4",
                     rdata, mis, mis_b, busy_n);
        end
        drive_idle();
        @(negedge CLK);
        #1;
        checks++;
        if (MISALIGN !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after_ack: got %b required 0", MISALIGN);
        end
        model_apply(4'b0, 3'b101, 32'h1, 32'hBEEF, exp_rd, exp_mis);
        do_access(4'b0, 3'b101, 32'h1, 32'hBEEF, busy_n, rdata, mis, mis_b);
        checks++;
        if (mis !== 1'b1) begin
            errors++;
            $display("FAIL misalign_sh_flag: got %b required 1", mis);
        end
        model_apply(4'b1010, 3'b0, 32'h0, 32'h0, exp_rd, exp_mis);
        do_access(4'b1010, 3'b0, 32'h0, 32'h0, busy_n, rdata, mis, mis_b);
        checks++;
        if (rdata !== 32'hCAFEF00D || mis !== 1'b0) begin
            errors++;
            $display("FAIL misalign_sh_no_write: got %h mis %b required cafef00d 0", rdata, mis);
        end
    endtask
`else
    task automatic test_natural_align();
        int busy_n; logic [31:0] rdata, exp_rd; logic mis, mis_b, exp_mis;
        model_apply(4'b0, 3'b110, 32'h10, 32'h11223344, exp_rd, exp_mis);
        do_access(4'b0, 3'b110, 32'h10, 32'h11223344, busy_n, rdata, mis, mis_b);
        model_apply(4'b1101, 3'b0, 32'h13, 32'h0, exp_rd, exp_mis);
        do_access(4'b1101, 3'b0, 32'h13, 32'h0, busy_n, rdata, mis, mis_b);
        checks++;
        if (rdata !== 32'h00001122 || mis !== 1'b0) begin
            errors++;
            $display("FAIL align_lhu: got %h mis %b required 00001122 0", rdata, mis);
        end
        model_apply(4'b0, 3'b101, 32'h11, 32'hBEEF, exp_rd, exp_mis);
        do_access(4'b0, 3'b101, 32'h11, 32'hBEEF, busy_n, rdata, mis, mis_b);
        model_apply(4'b1010, 3'b0, 32'h12, 32'h0, exp_rd, exp_mis);
        do_access(4'b1010, 3'b0, 32'h12, 32'h0, busy_n, rdata, mis, mis_b);
        checks++;
        if (rdata !== 32'h1122BEEF || mis !== 1'b0) begin
            errors++;
            $display("FAIL align_sh_lw: got %h mis %b required 1122beef 0", rdata, mis);
        end
    endtask
`endif

    initial begin
        drive_idle();
        RST = 1'b0;
        test_reset();
        test_fill();
        test_word();
        test_subword();
        test_reset_mid_busy();
        test_back_to_back();
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
        test_misalign();
`else
        test_natural_align();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_memory

`default_nettype wire
